// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven_segment_fun tile: display modes, rotation
// direction, button bit positions in ui_in, default timing and the hex font.
package seven_segment_pkg;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_ANIM  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_MODE  = 2;
  localparam int unsigned BTN_CLEAR = 3;
  localparam int unsigned NUM_BTNS  = 4;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned ANIM_CYCLES_DEF     = 2_000_000;

  // Segments a..g on bits 0..6, active-high; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_decode(input logic [3:0] value);
    return HEX_FONT[value];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus run-length counter; emits one registered pulse per
// press once the synced input has been high for DEBOUNCE_CYCLES cycles.
// Ports: clk, rst_n (async, active-low), btn_in (raw button), press (1-cycle pulse).
module button_debounce
  import seven_segment_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;

  // Counter saturates one past the firing value so a held button never re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      press   <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      press <= r_sync2 && (r_cnt == CNT_FIRE);
    end
  end

endmodule

// File: rtl/seven_segment_fun.sv
// One common-cathode 7-segment digit driven by four debounced push-buttons:
// hex counter (COUNT) or a rotating single-segment animation (ANIM).
// Ports: clk, rst_n (async, active-low), ena (ignored),
//   ui_in[3:0] = up/down/mode/clear buttons, uo_out[6:0] = segments a..g,
//   uo_out[7] = mode (1 = ANIM), uio_in unused, uio_out/uio_oe tied to 0.
// Build option: define SEG_ANIM_EN to include ANIM mode; otherwise btn_mode is
// ignored, mode stays COUNT and uo_out[7] is 0.
module seven_segment_fun
  import seven_segment_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned ANIM_CYCLES     = ANIM_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [NUM_BTNS-1:0] w_press;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_in(ui_in[gi]),
      .press (w_press[gi])
    );
  end

  // Simultaneous up and down cancel each other.
  logic w_step_up;
  logic w_step_dn;
  assign w_step_up = w_press[BTN_UP] & ~w_press[BTN_DOWN];
  assign w_step_dn = w_press[BTN_DOWN] & ~w_press[BTN_UP];

  logic [3:0] r_value;
  logic [3:0] w_value_nxt;
  logic [6:0] w_seg;
  logic       w_mode_bit;
  logic       w_unused;

`ifdef SEG_ANIM_EN
  localparam int unsigned ANIM_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_CYCLES - 1);
  localparam logic [2:0] POS_LAST = 3'd5;

  mode_e             r_mode;
  mode_e             w_mode_nxt;
  dir_e              r_dir;
  dir_e              w_dir_nxt;
  logic [2:0]        r_pos;
  logic [2:0]        w_pos_nxt;
  logic [ANIM_W-1:0] r_anim_cnt;
  logic [ANIM_W-1:0] w_anim_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value    <= '0;
      r_mode     <= MODE_COUNT;
      r_dir      <= DIR_CW;
      r_pos      <= '0;
      r_anim_cnt <= '0;
    end else begin
      r_value    <= w_value_nxt;
      r_mode     <= w_mode_nxt;
      r_dir      <= w_dir_nxt;
      r_pos      <= w_pos_nxt;
      r_anim_cnt <= w_anim_nxt;
    end
  end

  // Press handling (clear > mode > up/down) and the animation timer.
  always_comb begin
    w_value_nxt = r_value;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_pos_nxt   = r_pos;
    w_anim_nxt  = r_anim_cnt;
    if (w_press[BTN_CLEAR]) begin
      w_value_nxt = '0;
      w_pos_nxt   = '0;
      w_dir_nxt   = DIR_CW;
      w_anim_nxt  = '0;
    end else if (w_press[BTN_MODE]) begin
      w_mode_nxt = (r_mode == MODE_COUNT) ? MODE_ANIM : MODE_COUNT;
      w_anim_nxt = '0;
    end else if (r_mode == MODE_COUNT) begin
      if (w_step_up) begin
        w_value_nxt = r_value + 4'd1;
      end else if (w_step_dn) begin
        w_value_nxt = r_value - 4'd1;
      end
      w_anim_nxt = '0;
    end else begin
      if (w_step_up) begin
        w_dir_nxt = DIR_CW;
      end else if (w_step_dn) begin
        w_dir_nxt = DIR_CCW;
      end
      if (r_anim_cnt == ANIM_LAST) begin
        w_anim_nxt = '0;
        if (r_dir == DIR_CW) begin
          w_pos_nxt = (r_pos == POS_LAST) ? 3'd0 : r_pos + 3'd1;
        end else begin
          w_pos_nxt = (r_pos == 3'd0) ? POS_LAST : r_pos - 3'd1;
        end
      end else begin
        w_anim_nxt = r_anim_cnt + ANIM_W'(1);
      end
    end
  end

  assign w_seg      = (r_mode == MODE_ANIM) ? 7'(7'd1 << r_pos) : hex_decode(r_value);
  assign w_mode_bit = r_mode;
  assign w_unused   = &{1'b0, ena, uio_in, ui_in[7:4]};
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else begin
      r_value <= w_value_nxt;
    end
  end

  // Press handling: clear wins over up/down.
  always_comb begin
    w_value_nxt = r_value;
    if (w_press[BTN_CLEAR]) begin
      w_value_nxt = '0;
    end else if (w_step_up) begin
      w_value_nxt = r_value + 4'd1;
    end else if (w_step_dn) begin
      w_value_nxt = r_value - 4'd1;
    end
  end

  assign w_seg      = hex_decode(r_value);
  assign w_mode_bit = MODE_COUNT;
  assign w_unused   = &{1'b0, ena, uio_in, ui_in[7:4], w_press[BTN_MODE], 1'(ANIM_CYCLES & 1)};
`endif

  // Display register: depends only on state, never directly on ui_in.
  logic [7:0] r_uo_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo_out <= {1'b0, HEX_FONT[0]};
    end else begin
      r_uo_out <= {w_mode_bit, w_seg};
    end
  end

  assign uo_out  = r_uo_out;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_fun.sv
// Self-checking bench for seven_segment_fun with DEBOUNCE_CYCLES=8, ANIM_CYCLES=4.
// Expected displays are pushed to a scoreboard when buttons are driven and
// popped once the display has had time to settle.
module tb_seven_segment_fun;

  localparam int unsigned DEB  = 8;
  localparam int unsigned ANIM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;
  int m_value  = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_fun #(
    .DEBOUNCE_CYCLES(DEB),
    .ANIM_CYCLES    (ANIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_count();
    return {1'b0, font[m_value[3:0]]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [7:0] e;
    string      t;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, uo_out, e);
  endtask

  // Hold buttons for 'hold' cycles, release, let the display settle, compare.
  task automatic press_expect(input string tag, input logic [7:0] btns, input int hold,
                              input logic [7:0] e);
    push(tag, e);
    ui_in = btns;
    repeat (hold) tick();
    ui_in = 8'h00;
    repeat (8) tick();
    pop_check();
  endtask

`ifdef SEG_ANIM_EN
  // Compare every display change against the queued sequence; also check step spacing.
  task automatic watch_seq(input logic [7:0] btns, input int release_at);
    logic [7:0] last;
    logic [7:0] cur;
    logic [7:0] e;
    string      t;
    int         last_t;
    bit         first;
    first  = 1'b1;
    last_t = 0;
    last   = uo_out;
    ui_in  = btns;
    for (int cyc = 1; cyc <= 200 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (cyc == release_at) ui_in = 8'h00;
      cur = uo_out;
      if (cur !== last) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, cur, e);
        if (!first) check_eq("anim_period", 8'(cyc - last_t), 8'(ANIM));
        first  = 1'b0;
        last   = cur;
        last_t = cyc;
      end
    end
    if (exp_q.size() > 0) begin
      check_eq("anim_timeout", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
      tag_q.delete();
    end
    ui_in = 8'h00;
  endtask

  function automatic logic [6:0] ccw(input logic [6:0] s);
    return (s == 7'h01) ? 7'h20 : (s >> 1);
  endfunction

  // After btn_down in ANIM, each step must move one segment counter-clockwise.
  task automatic watch_ccw();
    logic [7:0] last;
    logic [7:0] cur;
    int         last_t;
    int         seen;
    ui_in = 8'h02;
    repeat (12) tick();
    ui_in = 8'h00;
    repeat (4) tick();
    @(negedge clk);
    last   = uo_out;
    last_t = 0;
    seen   = 0;
    for (int cyc = 1; cyc <= 100 && seen < 6; cyc++) begin
      @(negedge clk);
      cur = uo_out;
      if (cur !== last) begin
        check_eq("anim_ccw", cur, {1'b1, ccw(last[6:0])});
        if (seen > 0) check_eq("ccw_period", 8'(cyc - last_t), 8'(ANIM));
        seen++;
        last   = cur;
        last_t = cyc;
      end
    end
    check_eq("ccw_steps", 8'(seen), 8'd6);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    push("rst_uo", 8'h3F);
    pop_check();
    check_eq("rst_uio_oe", uio_oe, 8'h00);
    check_eq("rst_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    repeat (10) tick();
    push("idle_uo", exp_count());
    pop_check();

    // Debounce: too short, one short of threshold, long hold with one increment
    press_expect("short5", 8'h01, 5, exp_count());
    press_expect("short7", 8'h01, DEB - 1, exp_count());
    m_value = 1;
    push("hold_mid", exp_count());
    ui_in = 8'h01;
    repeat (14) tick();
    pop_check();
    push("hold_long", exp_count());
    repeat (20) tick();
    pop_check();
    ui_in = 8'h00;
    repeat (8) tick();
    push("hold_rel", exp_count());
    pop_check();
    m_value = 2;
    press_expect("exact8", 8'h01, DEB, exp_count());

    // Down with wrap 0 -> F, then up wraps back
    m_value = 1;
    press_expect("down_1", 8'h02, 20, exp_count());
    m_value = 0;
    press_expect("down_0", 8'h02, 20, exp_count());
    m_value = 15;
    press_expect("wrap_F", 8'h02, 20, exp_count());
    m_value = 0;
    press_expect("wrap_0", 8'h01, 20, exp_count());

    // Count up to 5 then clear together with up
    for (int i = 1; i <= 5; i++) begin
      m_value = i;
      press_expect("up_seq", 8'h01, 20, exp_count());
    end
    m_value = 0;
    press_expect("clear_up", 8'h09, 20, exp_count());
    press_expect("up_down", 8'h03, 20, exp_count());
    m_value = 1;
    press_expect("up_after", 8'h01, 20, exp_count());
    m_value = 0;
    press_expect("clear", 8'h08, 20, exp_count());

`ifdef SEG_ANIM_EN
    // Mode switch starts the clockwise rotation at segment a
    push("anim_a", 8'h81);
    push("anim_b", 8'h82);
    push("anim_c", 8'h84);
    push("anim_d", 8'h88);
    push("anim_e", 8'h90);
    push("anim_f", 8'hA0);
    push("anim_wrap", 8'h81);
    watch_seq(8'h04, 20);
    watch_ccw();
`else
    press_expect("mode_ignored", 8'h04, 20, exp_count());
`endif

    // Asynchronous reset between clock edges while a button is held
    ui_in = 8'h01;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", uo_out, 8'h3F);
    repeat (3) tick();
    check_eq("in_rst", uo_out, 8'h3F);
    ui_in = 8'h00;
    rst_n = 1'b1;
    m_value = 0;
    repeat (10) tick();
    push("post_rst", exp_count());
    pop_check();
    m_value = 1;
    press_expect("post_rst_up", 8'h01, 20, exp_count());
    check_eq("end_uio_oe", uio_oe, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
